ibex_mem_responder: RTL
=======================

Name: ibex_mem_responder

Overview:
Bus responder for the Ibex instruction and data request/grant/rvalid interfaces. It arbitrates both initiator ports onto a single-port SRAM with a fixed 1-cycle read latency, and it hosts a 4-bit LED register. Each transaction gets exactly one rvalid, and out-of-range or illegal accesses get an error response. It sits between ibex_core and ram_1p in the board top levels.

Parameters:
MemSize, 65536, SRAM size in bytes; must be a power of two.
MemStart, 32'h00000000, SRAM base address; aligned to MemSize.
LedAddr, 32'h00010000, word address of the LED register; must lie outside the SRAM range.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
instr_req_i  in  1  instruction request
instr_gnt_o  out  1  instruction grant (combinational, same cycle as request)
instr_rvalid_o  out  1  instruction response valid
instr_addr_i  in  32  instruction byte address
instr_rdata_o  out  32  instruction read data
instr_err_o  out  1  instruction error, valid with instr_rvalid_o
data_req_i  in  1  data request
data_gnt_o  out  1  data grant (combinational)
data_rvalid_o  out  1  data response valid
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_addr_i  in  32  data byte address
data_wdata_i  in  32  data write data
data_rdata_o  out  32  data read data
data_err_o  out  1  data error, valid with data_rvalid_o
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_be_o  out  4  SRAM byte enables
mem_addr_o  out  32  SRAM byte address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o
led_o  out  4  LED register

Behaviour:
- Reset values: all rvalid, err and gnt outputs are 0; rdata outputs are 0; led_o = 4'h0; arbitration priority register = instr; response stage is empty. Reset asserted mid-transaction discards any pending response, and no rvalid is issued for it.
- Grants: at most one grant per cycle. Grants are combinational from the requests and the priority register. No back-pressure: a request is always granted in the cycle it is the arbitration winner.
- Arbitration: if only one port requests, that port is granted. If both request, the port named by the priority register wins. After any grant, the priority register points to the port that was not granted. Under sustained dual requests the grants therefore strictly alternate.
- Address decode, applied to the granted request:
  - MEM: (addr & ~(MemSize-1)) == MemStart.
  - LED: {addr[31:2],2'b00} == LedAddr, data port only.
  - Otherwise ERR. Instruction fetches to LED decode as ERR.
- MEM: mem_req_o=1 in the grant cycle and the granted port's addr/we/be/wdata drive mem_*. The instruction port drives we=0 and be=4'hF. When there is no grant, mem_* outputs are all 0.
- LED: a write with be[0]=1 loads led_o <= wdata[3:0] at the end of the grant cycle. A write with be[0]=0 leaves led_o unchanged. A read returns {28'h0, led_o}.
- ERR: no SRAM access and no LED update.
- Response: one registered stage holds the valid flag, port id, and kind (MEM/LED/ERR).
  - rvalid is asserted on the granted port exactly 1 cycle after the grant, for reads and for writes alike.
  - rdata: MEM gives mem_rdata_i, LED gives the LED read value, ERR gives 0. err=1 only for ERR.
  - The non-responding port sees rvalid=0 and rdata=0.
- Back-to-back: a new grant may occur in the same cycle the previous response is presented. Throughput is 1 transaction/cycle with no bubbles.
- No response ordering hazard exists: latency is fixed at 1 and at most one transaction is outstanding per cycle.

Test Plan:
- Reset, then instr_req_i=1, instr_addr_i=0x80 with SRAM word[0x20]=0x00000013 -> instr_gnt_o=1 in the same cycle; next cycle instr_rvalid_o=1, instr_rdata_o=0x00000013, instr_err_o=0.
- Data write addr=0x100, wdata=0xDEADBEEF, be=4'b0011, then a read of 0x100 -> mem_be_o=4'b0011 in the write grant cycle; each access gets data_rvalid_o exactly 1 cycle after its grant; the read returns 0x????BEEF as stored in SRAM.
- Both ports requesting continuously for 6 cycles after reset -> grants in order I,D,I,D,I,D; each rvalid is on the matching port one cycle later; no cycle has both gnt outputs high.
- Data write to LedAddr with wdata=0xA5, be=4'b0001 -> led_o=4'h5 next cycle; a read of LedAddr returns 0x00000005, err=0. A write with be=4'b1110 leaves led_o unchanged.
- Data read at 0x00020000 and instr fetch at LedAddr -> each is granted, mem_req_o=0, rvalid next cycle with err=1 and rdata=0.
- rst_ni deasserted-then-asserted (pulled low) in the cycle after a grant -> no rvalid appears on either port and led_o=0. After release, a new request completes normally.

Source files
------------

// File: rtl/ibex_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ibex_mem_responder
//  Purpose  : Bus responder for the Ibex instruction and data
//             request/grant/rvalid ports. Arbitrates both initiators onto a
//             single-port SRAM with 1-cycle read latency, hosts a 4-bit LED
//             register and returns an error response for unmapped accesses.
//  Ports    : clk_i, rst_ni            - clock, async active-low reset
//             instr_*                   - instruction fetch port (read only)
//             data_*                    - data load/store port
//             mem_*                     - single-port SRAM master
//             led_o                     - LED register value
//  Revision : 1.0 - initial release
// ============================================================================
module ibex_mem_responder #(
  parameter int unsigned MemSize  = 65536,
  parameter logic [31:0] MemStart = 32'h00000000,
  parameter logic [31:0] LedAddr  = 32'h00010000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  led_o
);

  localparam logic [31:0] C_MEM_MASK = ~(MemSize - 32'd1);

  typedef enum logic [1:0] {
    KIND_MEM = 2'd0,
    KIND_LED = 2'd1,
    KIND_ERR = 2'd2
  } kind_e;

  typedef enum logic [0:0] {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  port_e       r_prio;
  logic        r_rsp_valid;
  port_e       r_rsp_port;
  kind_e       r_rsp_kind;
  logic [3:0]  r_led;

  logic        w_gnt_instr;
  logic        w_gnt_data;
  logic        w_any_gnt;
  logic [31:0] w_addr;
  logic        w_hit_mem;
  logic        w_hit_led;
  kind_e       w_kind;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_instr;
  logic        w_rsp_data;

  // A lone requester always wins; on contention the priority register decides.
  assign w_gnt_instr = instr_req_i && (!data_req_i  || (r_prio == PORT_INSTR));
  assign w_gnt_data  = data_req_i  && (!instr_req_i || (r_prio == PORT_DATA));
  assign w_any_gnt   = w_gnt_instr || w_gnt_data;

  assign instr_gnt_o = w_gnt_instr;
  assign data_gnt_o  = w_gnt_data;

  // Decode only the winning address; the LED register is invisible to fetches.
  assign w_addr    = w_gnt_data ? data_addr_i : instr_addr_i;
  assign w_hit_mem = ((w_addr & C_MEM_MASK) == MemStart);
  assign w_hit_led = w_gnt_data && ({w_addr[31:2], 2'b00} == LedAddr);

  always_comb begin
    w_kind = KIND_ERR;
    if (w_hit_mem) begin
      w_kind = KIND_MEM;
    end else if (w_hit_led) begin
      w_kind = KIND_LED;
    end
  end

  // SRAM master: quiet (all zero) unless a granted access targets memory.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (w_any_gnt && (w_kind == KIND_MEM)) begin
      mem_req_o  = 1'b1;
      mem_addr_o = w_addr;
      if (w_gnt_data) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio      <= PORT_INSTR;
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= PORT_INSTR;
      r_rsp_kind  <= KIND_ERR;
      r_led       <= 4'h0;
    end else begin
      r_rsp_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_rsp_port <= w_gnt_data ? PORT_DATA : PORT_INSTR;
        r_rsp_kind <= w_kind;
        // Hand priority to the loser so sustained contention alternates.
        r_prio     <= w_gnt_data ? PORT_INSTR : PORT_DATA;
      end
      if (w_gnt_data && (w_kind == KIND_LED) && data_we_i && data_be_i[0]) begin
        r_led <= data_wdata_i[3:0];
      end
    end
  end

  assign led_o = r_led;

  // Response payload. SRAM data is only valid in this cycle, so it is muxed
  // straight through rather than captured.
  always_comb begin
    w_rsp_rdata = 32'h0;
    case (r_rsp_kind)
      KIND_MEM: w_rsp_rdata = mem_rdata_i;
      KIND_LED: w_rsp_rdata = {28'h0, r_led};
      default:  w_rsp_rdata = 32'h0;
    endcase
  end

  assign w_rsp_instr = r_rsp_valid && (r_rsp_port == PORT_INSTR);
  assign w_rsp_data  = r_rsp_valid && (r_rsp_port == PORT_DATA);

  assign instr_rvalid_o = w_rsp_instr;
  assign instr_rdata_o  = w_rsp_instr ? w_rsp_rdata : 32'h0;
  assign instr_err_o    = w_rsp_instr && (r_rsp_kind == KIND_ERR);

  assign data_rvalid_o  = w_rsp_data;
  assign data_rdata_o   = w_rsp_data ? w_rsp_rdata : 32'h0;
  assign data_err_o     = w_rsp_data && (r_rsp_kind == KIND_ERR);

endmodule
`default_nettype wire
